// File: rtl/latent_decoder_seq_if.sv
// Latent-pair handshake, coefficient write port and pixel result bus
// for the latent decoder.
interface latent_decoder_seq_if #(
    parameter int DATA_W = 20
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] z0;
    logic signed [DATA_W-1:0] z1;
    logic                     wr_en;
    logic [4:0]               wr_addr;
    logic signed [DATA_W-1:0] wr_data;
    logic [8:0]               Y;
    logic                     out_valid;

    modport master (
        output in_valid, z0, z1, wr_en, wr_addr, wr_data,
        input  in_ready, Y, out_valid
    );

    modport slave (
        input  in_valid, z0, z1, wr_en, wr_addr, wr_data,
        output in_ready, Y, out_valid
    );
endinterface

// File: rtl/latent_decoder_seq.sv
// Latent decoder: rebuilds a 3x3 binary pixel window from the two
// latent means using one shared multiplier over 18 steps.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a latent pair; coefficient writes accepted
// CALC   | step 0..17; even step = bias + w0*z0, odd step = + w1*z1
// DONE   | publish pixels on the next edge, then back to IDLE
module latent_decoder_seq #(
    parameter int DATA_W = 20,
    parameter int FRAC   = 16,
    parameter int ACC_W  = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    latent_decoder_seq_if.slave bus
);

    localparam int N_COEF = 27;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [4:0]                step_q, step_d;
    logic signed [DATA_W-1:0]  z0_q, z0_d;
    logic signed [DATA_W-1:0]  z1_q, z1_d;
    logic signed [DATA_W-1:0]  coef_q [N_COEF];
    logic signed [DATA_W-1:0]  coef_d [N_COEF];
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [8:0]                y_next_q, y_next_d;
    logic [8:0]                y_q, y_d;
    logic                      out_valid_q, out_valid_d;

    logic [3:0]                pix_k;
    logic [4:0]                w_idx;
    logic [4:0]                b_idx;
    logic signed [DATA_W-1:0]  mul_a;
    logic signed [DATA_W-1:0]  mul_b;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   term;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W:0]     sum_final;

    // Shared datapath: pick operands for the current step, scale the product.
    always_comb begin
        pix_k     = step_q[4:1];
        w_idx     = ({1'b0, pix_k} << 1) + {1'b0, pix_k} + {4'b0, step_q[0]};
        b_idx     = ({1'b0, pix_k} << 1) + {1'b0, pix_k} + 5'd2;
        mul_a     = step_q[0] ? z1_q : z0_q;
        mul_b     = coef_q[w_idx];
        prod      = mul_a * mul_b;
        term      = ACC_W'(prod >>> FRAC);
        bias_ext  = {{(ACC_W-DATA_W){coef_q[b_idx][DATA_W-1]}}, coef_q[b_idx]};
        // Two full-scale terms plus a full-scale bias can exceed ACC_W, so the
        // final sum carries one guard bit before the sign test.
        sum_final = {acc_q[ACC_W-1], acc_q} + {term[ACC_W-1], term};
    end

    // Next-state, coefficient write and accumulation logic.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        z0_d        = z0_q;
        z1_d        = z1_q;
        coef_d      = coef_q;
        acc_d       = acc_q;
        y_next_d    = y_next_q;
        y_d         = y_q;
        out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.wr_en && (bus.wr_addr < 5'(N_COEF))) begin
                    coef_d[bus.wr_addr] = bus.wr_data;
                end
                if (bus.in_valid) begin
                    z0_d    = bus.z0;
                    z1_d    = bus.z1;
                    step_d  = 5'd0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (!step_q[0]) begin
                    acc_d = bias_ext + term;
                end else begin
                    y_next_d[pix_k] = (sum_final > 0);
                end
                if (step_q == 5'd17) begin
                    step_d  = 5'd0;
                    state_d = S_DONE;
                end else begin
                    step_d = step_q + 5'd1;
                end
            end
            S_DONE: begin
                y_d         = y_next_q;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            step_q      <= 5'd0;
            z0_q        <= '0;
            z1_q        <= '0;
            acc_q       <= '0;
            y_next_q    <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < N_COEF; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            z0_q        <= z0_d;
            z1_q        <= z1_d;
            acc_q       <= acc_d;
            y_next_q    <= y_next_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < N_COEF; i++) begin
                coef_q[i] <= coef_d[i];
            end
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.Y         = y_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_latent_decoder_seq.sv
// Directed bench for the latent decoder with hand-computed pixel windows.
module tb_latent_decoder_seq;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    latent_decoder_seq_if #(.DATA_W(20)) bus ();

    latent_decoder_seq #(.DATA_W(20), .FRAC(16), .ACC_W(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [19:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    // Presents a latent pair (optionally with a same-cycle write) for one edge.
    task automatic accept(input logic [19:0] a, input logic [19:0] b,
                          input logic we, input logic [4:0] wa, input logic [19:0] wd);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.z0       = a;
        bus.z1       = b;
        bus.wr_en    = we;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.wr_en    = 1'b0;
    endtask

    // Counts edges until out_valid (bounded) and cycles with in_ready low.
    task automatic wait_ov(output int lat, output int busy);
        lat  = 0;
        busy = 0;
        while (!bus.out_valid && lat < 40) begin
            if (!bus.in_ready) busy++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic count_ov(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) cnt++;
        end
    endtask

    task automatic run_job(input string tag, input logic [19:0] a, input logic [19:0] b,
                           input logic [8:0] exp_y);
        int lat;
        int busy;
        chk({tag, "_ready_pre"}, 32'(bus.in_ready), 32'd1);
        accept(a, b, 1'b0, 5'd0, 20'd0);
        wait_ov(lat, busy);
        chk({tag, "_latency"}, 32'(lat), 32'd19);
        chk({tag, "_y"}, 32'(bus.Y), 32'(exp_y));
        @(posedge clk);
        #1;
        chk({tag, "_ov_width"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int busy;
        int cnt;
        n_vec        = 0;
        n_miss       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.z0       = '0;
        bus.z1       = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;

        do_reset();
        chk("rst_y", 32'(bus.Y), 32'd0);
        chk("rst_ov", 32'(bus.out_valid), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);

        run_job("zero_coef", 20'h10000, 20'h10000, 9'h000);

        // 1.0 * 0.5 -> +0.5 on pixel 0; in_ready low for exactly 19 cycles.
        wr(5'd0, 20'h10000);
        chk("single_ready_pre", 32'(bus.in_ready), 32'd1);
        accept(20'h08000, 20'h12345, 1'b0, 5'd0, 20'd0);
        wait_ov(lat, busy);
        chk("single_latency", 32'(lat), 32'd19);
        chk("single_busy", 32'(busy), 32'd19);
        chk("single_y", 32'(bus.Y), 32'h001);
        @(posedge clk);
        #1;
        chk("single_ov_width", 32'(bus.out_valid), 32'd0);
        chk("single_ready_post", 32'(bus.in_ready), 32'd1);

        // In-flight accept and write must both be dropped.
        accept(20'h08000, 20'h12345, 1'b0, 5'd0, 20'd0);
        repeat (5) @(posedge clk);
        accept(20'h00000, 20'h00000, 1'b1, 5'd0, 20'h00000);
        wait_ov(lat, busy);
        chk("busy_y", 32'(bus.Y), 32'h001);
        count_ov(30, cnt);
        chk("busy_no_extra_job", 32'(cnt), 32'd0);
        run_job("busy_coef_kept", 20'h08000, 20'h12345, 9'h001);

        // Sum exactly zero is not positive; one LSB above is.
        do_reset();
        wr(5'd12, 20'h10000);
        wr(5'd14, 20'hF0000);
        run_job("zero_bnd", 20'h10000, 20'h00000, 9'h000);
        wr(5'd14, 20'hF0001);
        run_job("zero_bnd_p1", 20'h10000, 20'h00000, 9'h010);

        // 1 LSB * -1 LSB floors to -1.
        do_reset();
        wr(5'd24, 20'h00001);
        wr(5'd26, 20'h00001);
        run_job("trunc_b1", 20'hFFFFF, 20'h00000, 9'h000);
        wr(5'd26, 20'h00002);
        run_job("trunc_b2", 20'hFFFFF, 20'h00000, 9'h100);

        // Write in the accept cycle is used by that job (Bd_0 = 1 LSB).
        do_reset();
        accept(20'h00000, 20'h00000, 1'b1, 5'd2, 20'h00001);
        wait_ov(lat, busy);
        chk("same_cycle_lat", 32'(lat), 32'd19);
        chk("same_cycle_y", 32'(bus.Y), 32'h001);

        // Extremes: (-8)*(-8) = +64 per term; (-8)*(8-2^-16) = -64+2^-13.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            wr(5'(3 * k), 20'h80000);
            wr(5'(3 * k + 1), 20'h80000);
            wr(5'(3 * k + 2), 20'h7FFFF);
        end
        run_job("ext_pos", 20'h80000, 20'h80000, 9'h1FF);
        run_job("ext_neg", 20'h7FFFF, 20'h7FFFF, 9'h000);

        // Reset in step 9 aborts the job and clears coefficients.
        do_reset();
        wr(5'd0, 20'h10000);
        accept(20'h10000, 20'h00000, 1'b0, 5'd0, 20'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_ov", 32'(bus.out_valid), 32'd0);
        chk("abort_y", 32'(bus.Y), 32'd0);
        chk("abort_ready", 32'(bus.in_ready), 32'd1);
        count_ov(25, cnt);
        chk("abort_no_ov", 32'(cnt), 32'd0);
        run_job("abort_cleared", 20'h10000, 20'h00000, 9'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
